wb_ram_slave: RTL and testbench
===============================

Name: wb_ram_slave

Overview:
- Wishbone B4 classic-cycle responder: a word-organised RAM that terminates pipeline-side bus requests on the memory side of the system bus.
- Provides byte-lane writes, a configurable number of wait states, and an error termination for illegal addresses.
- Acts as the bus memory behind the pipeline's Wishbone master.

Parameters:
- ADDR_BASE, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.
- DEPTH_WORDS, 1024: number of 32-bit words; valid range 1..65536.
- WAIT_STATES, 0: extra cycles inserted before termination; valid range 0..15.

Ports:
- clk_i  in  1  single clock; all logic on rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- wbs_cyc_i  in  1  bus cycle valid.
- wbs_stb_i  in  1  strobe; a transfer is requested only when cyc and stb are both high.
- wbs_we_i  in  1  1 = write, 0 = read.
- wbs_addr_i  in  32  byte address.
- wbs_sel_i  in  4  byte-lane enables; bit n maps to bits [8n+7:8n].
- wbs_dat_i  in  32  write data.
- wbs_dat_o  out  32  read data.
- wbs_ack_o  out  1  normal termination, registered.
- wbs_err_o  out  1  error termination, registered.

Behaviour:
- Reset: asynchronous assert when rst_n_i = 0; synchronous release.
  - Reset values: wbs_ack_o = 0, wbs_err_o = 0, wbs_dat_o = 0, FSM = IDLE, wait counter = 0.
  - RAM contents are not reset and are undefined after power-up.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - No action unless cyc & stb are sampled high.
  - On a request, decode the address.
  - Illegal address: addr[1:0] != 0, or addr < ADDR_BASE, or addr >= ADDR_BASE + 4*DEPTH_WORDS.
    - Assert err_o for 1 cycle after this edge, regardless of WAIT_STATES. Go to RESP.
    - No RAM access; dat_o = 0.
  - Legal address, WAIT_STATES = 0: perform the access at this edge; ack_o high next cycle. Go to RESP.
  - Legal address, WAIT_STATES > 0: load counter = WAIT_STATES. Go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1 and cyc & stb are still high: perform the access and assert ack_o. Go to RESP.
  - Latency: the request sampled at edge T is acknowledged at edge T+W, so ack_o is visible in cycle T+W+1.
  - Abort: if cyc drops during WAIT, go to IDLE. No write, no ack, no err.
  - If stb drops while cyc stays high, treat it the same as an abort.
- Access performed on the terminating edge:
  - Word index = (addr - ADDR_BASE) >> 2.
  - Write: update only the lanes whose sel bit is set. sel = 4'b0000 still acks with memory unchanged.
  - Read: dat_o = the full 32-bit word, regardless of sel.
  - Address, data, sel and we are sampled at the terminating edge, not latched at request.
- RESP:
  - Lasts exactly 1 cycle. ack_o or err_o is high and dat_o holds read data (0 for writes and errors).
  - Next edge: clear ack_o, err_o and dat_o; go to IDLE.
  - cyc/stb are ignored in RESP. A master that holds stb one cycle past ack does not start a duplicate transfer.
  - A new request is accepted at the earliest one edge after RESP. The minimum back-to-back period is 2 + WAIT_STATES cycles.
- Invariants:
  - ack_o and err_o are never high together.
  - Neither is high outside RESP.
  - stb without cyc is ignored.
- Reset mid-operation: any state returns to IDLE immediately.
  - A write still in WAIT is not committed.
  - A RESP pulse is cut short.

Test Plan:
- Default params: write 0xDEADBEEF to 0x10 (sel = 4'hF), then read 0x10 -> each ack arrives 1 cycle after the request edge; read dat_o = 0xDEADBEEF; err_o stays 0.
- Byte lanes: preload 0x11223344 at 0x20, then write 0xAABBCCDD with sel = 4'b0101 -> readback = 0x11BB33DD. A write with sel = 0 -> ack, and readback is unchanged.
- WAIT_STATES = 2: read request sampled at edge T -> ack_o high in cycle T+3 only. Master holds stb one extra cycle -> exactly one ack per request.
- Error: read at 0x1000 (DEPTH 1024 words) and at 0x0000_0002 -> err_o pulses 1 cycle after the request edge; ack_o = 0; dat_o = 0; RAM unchanged.
- Abort, WAIT_STATES = 3: start a write to 0x40, drop cyc after 1 cycle -> no ack and no err; a later read of 0x40 returns the old data.
- Async reset: pull rst_n_i low mid-WAIT of a write, between clock edges -> outputs 0 immediately. After release, a read of that address returns the old data and the FSM accepts a new request.

Source files
------------

// File: rtl/wb_ram_slave.sv
// Wishbone B4 classic-cycle RAM responder with byte lanes, configurable wait
// states and error termination for unaligned or out-of-window addresses.
module wb_ram_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_addr_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] LIMIT    = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_CNT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [3:0]         cnt_r;
  logic [3:0]         cnt_s;
  logic               ack_r;
  logic               err_r;
  logic [31:0]        dat_r;
  logic               access_s;
  logic               err_s;
  logic               req_s;
  logic               legal_s;
  logic [32:0]        offset_s;
  logic [IDX_W-1:0]   idx_s;
  logic [31:0]        dat_s;
  logic [31:0]        mem_r [DEPTH_WORDS];

  // Address decode: bit 32 of the offset is the borrow, i.e. addr below the base.
  always_comb begin
    req_s    = wbs_cyc_i & wbs_stb_i;
    offset_s = {1'b0, wbs_addr_i} - {1'b0, ADDR_BASE};
    legal_s  = (wbs_addr_i[1:0] == 2'b00) && !offset_s[32] && (offset_s[31:0] < LIMIT);
    idx_s    = offset_s[IDX_W+1:2];
  end

  // Next-state logic; the access always uses the bus values of the terminating edge.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    access_s = 1'b0;
    err_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          if (!legal_s) begin
            err_s   = 1'b1;
            state_s = RESP;
          end else if (WAIT_STATES == 32'd0) begin
            access_s = 1'b1;
            state_s  = RESP;
          end else begin
            cnt_s   = WAIT_CNT;
            state_s = WAIT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (!req_s) begin
          cnt_s   = 4'd0;
          state_s = IDLE;
        end else if (cnt_r <= 4'd1) begin
          cnt_s   = 4'd0;
          state_s = RESP;
          if (legal_s) begin
            access_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      RESP: begin
        cnt_s   = 4'd0;
        state_s = IDLE;
      end
      default: begin
        cnt_s   = 4'd0;
        state_s = IDLE;
      end
    endcase
  end

  // Read data is driven only for a read termination, zero otherwise.
  always_comb begin
    if (access_s && !wbs_we_i) begin
      dat_s = mem_r[idx_s];
    end else begin
      dat_s = 32'h0000_0000;
    end
  end

  // State, wait counter and registered bus outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      dat_r   <= 32'h0000_0000;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ack_r   <= access_s;
      err_r   <= err_s;
      dat_r   <= dat_s;
    end
  end

  // Byte-lane writes into the unreset storage array.
  always_ff @(posedge clk_i) begin
    if (access_s && wbs_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wbs_sel_i[b]) begin
          mem_r[idx_s][8*b +: 8] <= wbs_dat_i[8*b +: 8];
        end
      end
    end
  end

  assign wbs_ack_o = ack_r;
  assign wbs_err_o = err_r;
  assign wbs_dat_o = dat_r;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Scoreboard bench for wb_ram_slave: three instances (0, 2 and 3 wait states)
// driven by directed and random transfers against a transaction-level model.
module tb_wb_ram_slave;

  typedef struct {
    int          d;
    bit          is_err;
    int          at_edge;
    logic [31:0] dat;
    bit          chk_dat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        cyc_v  [3];
  logic        stb_v  [3];
  logic        we_v   [3];
  logic [31:0] addr_v [3];
  logic [3:0]  sel_v  [3];
  logic [31:0] wdat_v [3];
  logic [31:0] rdat_v [3];
  logic        ack_v  [3];
  logic        err_v  [3];

  int          edge_cnt = 0;
  int          checks   = 0;
  int          failures = 0;
  exp_t        exp_q [$];
  logic [31:0] mdl   [3][1024];
  bit   [3:0]  known [3][1024];
  exp_t        mon_e;
  int          mon_idx;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS_G = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
    wb_ram_slave #(
      .ADDR_BASE   (32'h0000_0000),
      .DEPTH_WORDS (1024),
      .WAIT_STATES (WS_G)
    ) u_dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .wbs_cyc_i  (cyc_v[g]),
      .wbs_stb_i  (stb_v[g]),
      .wbs_we_i   (we_v[g]),
      .wbs_addr_i (addr_v[g]),
      .wbs_sel_i  (sel_v[g]),
      .wbs_dat_i  (wdat_v[g]),
      .wbs_dat_o  (rdat_v[g]),
      .wbs_ack_o  (ack_v[g]),
      .wbs_err_o  (err_v[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic int ws_of(input int d);
    case (d)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  // Transaction-level model: a request held high for 'hold' consecutive edges
  // starting at edge t0 produces one response per completed bus transaction.
  task automatic model(input int d, input bit we, input logic [31:0] addr,
                       input logic [3:0] sel, input logic [31:0] dat,
                       input int t0, input int hold);
    int   w;
    int   t;
    int   wi;
    bit   legal;
    exp_t e;
    w     = ws_of(d);
    legal = (addr % 4 == 0) && (addr < 4 * 1024);
    wi    = legal ? int'(addr / 4) : 0;
    t     = 0;
    while (t < hold) begin
      e.d       = d;
      e.is_err  = !legal;
      e.dat     = 32'h0;
      e.chk_dat = 1'b1;
      if (!legal) begin
        e.at_edge = t0 + t;
        exp_q.push_back(e);
        t += 2;
      end else if (hold - t >= w + 1) begin
        e.at_edge = t0 + t + w;
        if (we) begin
          for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
              mdl[d][wi][8*b +: 8] = dat[8*b +: 8];
              known[d][wi][b]      = 1'b1;
            end
          end
        end else begin
          e.dat     = mdl[d][wi];
          e.chk_dat = (known[d][wi] == 4'hF);
        end
        exp_q.push_back(e);
        t += w + 2;
      end else begin
        t = hold;
      end
    end
  endtask

  task automatic xfer(input int d, input bit we, input logic [31:0] addr,
                      input logic [3:0] sel, input logic [31:0] dat, input int hold);
    cyc_v[d]  = 1'b1;
    stb_v[d]  = 1'b1;
    we_v[d]   = we;
    addr_v[d] = addr;
    sel_v[d]  = sel;
    wdat_v[d] = dat;
    @(posedge clk); #1;
    model(d, we, addr, sel, dat, edge_cnt, hold);
    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
    end
    cyc_v[d] = 1'b0;
    @(posedge clk); #1;
    repeat ($urandom_range(0, 2)) begin
      stb_v[d] = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    stb_v[d] = 1'b0;
  endtask

  task automatic wr(input int d, input logic [31:0] addr, input logic [3:0] sel,
                    input logic [31:0] dat);
    xfer(d, 1'b1, addr, sel, dat, ws_of(d) + 1);
  endtask

  task automatic rd(input int d, input logic [31:0] addr);
    xfer(d, 1'b0, addr, 4'($urandom_range(0, 15)), $urandom, ws_of(d) + 2);
  endtask

  // Scoreboard monitor: pops the oldest expectation of each instance.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        mon_idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
          if (mon_idx < 0 && exp_q[i].d == d) mon_idx = i;
        end
        if (ack_v[d] || err_v[d]) begin
          checks++;
          if (mon_idx < 0) begin
            failures++;
            $display("FAIL unexpected_resp dut=%0d edge=%0d ack=%0b err=%0b required=none",
                     d, edge_cnt, ack_v[d], err_v[d]);
          end else begin
            mon_e = exp_q[mon_idx];
            exp_q.delete(mon_idx);
            if (ack_v[d] !== !mon_e.is_err || err_v[d] !== mon_e.is_err ||
                mon_e.at_edge != edge_cnt || (mon_e.chk_dat && rdat_v[d] !== mon_e.dat)) begin
              failures++;
              $display("FAIL resp dut=%0d got edge=%0d ack=%0b err=%0b dat=%08h required edge=%0d err=%0b dat=%08h",
                       d, edge_cnt, ack_v[d], err_v[d], rdat_v[d],
                       mon_e.at_edge, mon_e.is_err, mon_e.dat);
            end
          end
        end else begin
          checks++;
          if (rdat_v[d] !== 32'h0) begin
            failures++;
            $display("FAIL idle_dat dut=%0d edge=%0d dat=%08h required=00000000",
                     d, edge_cnt, rdat_v[d]);
          end
          if (mon_idx >= 0 && exp_q[mon_idx].at_edge <= edge_cnt) begin
            checks++;
            failures++;
            $display("FAIL missing_resp dut=%0d edge=%0d got=none required edge=%0d err=%0b",
                     d, edge_cnt, exp_q[mon_idx].at_edge, exp_q[mon_idx].is_err);
            exp_q.delete(mon_idx);
          end
        end
      end
    end
  end

  task automatic check_zero(input string name);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ack_v[d] !== 1'b0 || err_v[d] !== 1'b0 || rdat_v[d] !== 32'h0) begin
        failures++;
        $display("FAIL %s dut=%0d ack=%0b err=%0b dat=%08h required all zero",
                 name, d, ack_v[d], err_v[d], rdat_v[d]);
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    int          d;
    int          w;
    int          r;
    int          h;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc_v[i] = 1'b0; stb_v[i] = 1'b0; we_v[i] = 1'b0;
      addr_v[i] = 32'h0; sel_v[i] = 4'h0; wdat_v[i] = 32'h0;
      for (int k = 0; k < 1024; k++) begin
        mdl[i][k]   = 32'h0;
        known[i][k] = 4'h0;
      end
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset_state");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 32; k++) wr(i, 32'(k * 4), 4'hF, $urandom);
      for (int k = 1020; k < 1024; k++) wr(i, 32'(k * 4), 4'hF, $urandom);
    end

    for (int i = 0; i < 3; i++) begin
      wr(i, 32'h10, 4'hF, 32'hDEAD_BEEF);
      rd(i, 32'h10);
      wr(i, 32'h20, 4'hF, 32'h1122_3344);
      wr(i, 32'h20, 4'b0101, 32'hAABB_CCDD);
      rd(i, 32'h20);
      wr(i, 32'h20, 4'b0000, 32'h5555_5555);
      rd(i, 32'h20);
      xfer(i, 1'b0, 32'h0000_1000, 4'hF, 32'h0, 1);
      xfer(i, 1'b0, 32'h0000_0002, 4'hF, 32'h0, 1);
      xfer(i, 1'b1, 32'h0000_0022, 4'hF, 32'hFFFF_FFFF, 1);
      xfer(i, 1'b1, 32'h0000_1000, 4'hF, 32'hFFFF_FFFF, 1);
      rd(i, 32'h20);
      rd(i, 32'hFFC);
    end

    // Aborted writes: cyc drops before the wait states expire.
    xfer(2, 1'b1, 32'h40, 4'hF, 32'h0BAD_0BAD, 2);
    rd(2, 32'h40);
    xfer(1, 1'b1, 32'h40, 4'hF, 32'h0BAD_0BAD, 1);
    rd(1, 32'h40);

    repeat (150) begin
      d = $urandom_range(0, 2);
      w = ws_of(d);
      r = $urandom_range(0, 9);
      if (r < 8) begin
        a = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 31) * 4)
                                        : 32'($urandom_range(1020, 1023) * 4);
      end else if (r == 8) begin
        a = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
      end else begin
        a = 32'h0000_1000 + 32'($urandom_range(0, 1023) * 4);
      end
      if (w > 0 && $urandom_range(0, 4) == 0) h = $urandom_range(1, w);
      else h = w + 1 + $urandom_range(0, 1);
      xfer(d, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom, h);
    end

    // Asynchronous reset mid-WAIT of a write on the 3-wait instance while the
    // zero-wait instance is presenting an ack.
    cyc_v[2] = 1'b1; stb_v[2] = 1'b1; we_v[2] = 1'b1;
    addr_v[2] = 32'h40; sel_v[2] = 4'hF; wdat_v[2] = 32'hCAFE_F00D;
    @(posedge clk); #1;
    cyc_v[0] = 1'b1; stb_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 32'h10;
    model(0, 1'b0, 32'h10, 4'hF, 32'h0, edge_cnt + 1, 1);
    @(posedge clk); #1;
    cyc_v[0] = 1'b0; stb_v[0] = 1'b0;
    checks++;
    if (ack_v[0] !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_ack dut=0 ack=%0b required=1", ack_v[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_zero("async_reset");
    cyc_v[2] = 1'b0; stb_v[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd(2, 32'h40);
    rd(0, 32'h10);
    wr(2, 32'h44, 4'hF, 32'h1357_9BDF);
    rd(2, 32'h44);

    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expectations got=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
